// File: rtl/adder_bist_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_bist_pkg
// Brief    : Shared types and constants for the 16-bit adder self-test
//            controller: FSM states, LFSR geometry and the directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
package adder_bist_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    // LFSR geometry: x^33 + x^20 + 1
    localparam int c_lfsr_w      = 33;
    localparam int c_lfsr_tap_hi = 33;
    localparam int c_lfsr_tap_lo = 20;

    // One stimulus vector for the adder under test
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
    } bist_vec_t;

    // Directed corner vectors issued at the start of every run
    localparam bist_vec_t c_dir_v0 = '{a: 16'h0000, b: 16'h0000, cin: 1'b0};
    localparam bist_vec_t c_dir_v1 = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0};
    localparam bist_vec_t c_dir_v2 = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1};
    localparam bist_vec_t c_dir_v3 = '{a: 16'hAAAA, b: 16'h5555, cin: 1'b1};

    function automatic bist_vec_t dir_vec(input logic [1:0] idx);
        bist_vec_t v;
        v = c_dir_v0;
        case (idx)
            2'd1:    v = c_dir_v1;
            2'd2:    v = c_dir_v2;
            2'd3:    v = c_dir_v3;
            default: v = c_dir_v0;
        endcase
        return v;
    endfunction

    // Pseudo-random vector: low half -> a, high half -> b, MSB -> cin
    function automatic bist_vec_t lfsr_vec(input logic [c_lfsr_w-1:0] q);
        bist_vec_t v;
        v.a   = q[15:0];
        v.b   = q[31:16];
        v.cin = q[32];
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_bist_ctrl_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : bist_lfsr
// Brief    : 33-bit Fibonacci LFSR (x^33 + x^20 + 1) with synchronous seed
//            load and step enable; supplies pseudo-random adder operands.
// Revision : 1.0 - initial release
// ============================================================================
module bist_lfsr
    import adder_bist_pkg::*;
#(
    parameter logic [c_lfsr_w-1:0] SEED = 33'h1_2345_6789
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    output logic [c_lfsr_w-1:0] q
);

    logic w_fb;

    assign w_fb = q[c_lfsr_tap_hi-1] ^ q[c_lfsr_tap_lo-1];

    // Load has priority so a new run always starts from the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (step) begin
            q <= {q[c_lfsr_w-2:0], w_fb};
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_bist_ctrl
// Brief    : Self-test controller for 16-bit adders. Issues 4 directed plus
//            LFSR vectors, compares the returned sum against a golden value
//            delayed by the adder latency, and reports errors and a verdict.
//            Optional macro ADDER_BIST_FAIL_CAPTURE_EN adds first-failure
//            capture outputs.
// Revision : 1.0 - initial release
// ============================================================================
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int                  NUM_VECTORS = 1024,
    parameter int                  LAT         = 0,
    parameter logic [c_lfsr_w-1:0] SEED        = 33'h1_2345_6789
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic        cin,
    input  logic [15:0] s,
    input  logic        cout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] vec_count
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    ,
    output logic [15:0] fail_a,
    output logic [15:0] fail_b,
    output logic        fail_cin,
    output logic [16:0] fail_sum,
    output logic        fail_valid
`endif
);

    localparam logic [15:0] c_num_vec    = 16'(NUM_VECTORS);
    // DRAIN lasts max(LAT,1) cycles; the counter holds the remaining count minus one
    localparam logic [15:0] c_drain_last = 16'(((LAT > 0) ? LAT : 1) - 1);

    bist_state_t         r_state;
    logic                r_issue_done;
    logic [15:0]         r_drain_cnt;

    logic [c_lfsr_w-1:0] w_lfsr_q;
    logic                w_entry;
    logic                w_issue;
    logic                w_prn;
    logic [15:0]         w_idx;
    bist_vec_t           w_vec;
    logic [16:0]         w_golden;

    logic [LAT:0]        r_exp_vld;
    logic [LAT:0][16:0]  r_exp_sum;
    logic                r_cmp_vld;
    logic [16:0]         r_cmp_exp;
    logic [16:0]         r_cmp_got;
    logic                w_mismatch;

    // A run starts from IDLE or DONE; start is ignored while busy
    assign w_entry  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_issue  = w_entry ||
                      ((r_state == ST_RUN) && !r_issue_done && (vec_count != c_num_vec));
    assign w_idx    = w_entry ? 16'd0 : vec_count;
    assign w_prn    = w_issue && (w_idx >= 16'd4);
    assign w_vec    = w_prn ? lfsr_vec(w_lfsr_q) : dir_vec(w_idx[1:0]);
    assign w_golden = {1'b0, w_vec.a} + {1'b0, w_vec.b} + {16'd0, w_vec.cin};

    bist_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_entry),
        .step  (w_prn),
        .q     (w_lfsr_q)
    );

    // Run sequencing: RUN issues the vectors plus one settle cycle, DRAIN
    // waits out the adder latency, DONE holds the verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_issue_done <= 1'b0;
            r_drain_cnt  <= 16'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            a            <= 16'd0;
            b            <= 16'd0;
            cin          <= 1'b0;
            vec_count    <= 16'd0;
        end else begin
            if (w_issue) begin
                a   <= w_vec.a;
                b   <= w_vec.b;
                cin <= w_vec.cin;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_issue_done <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        vec_count    <= 16'd1;
                    end
                end
                ST_RUN: begin
                    if (r_issue_done) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= c_drain_last;
                    end else if (vec_count == c_num_vec) begin
                        r_issue_done <= 1'b1;
                    end else begin
                        vec_count <= vec_count + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == 16'd0) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Golden sums ride alongside the adder pipeline; the tail is paired with
    // the registered adder response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp_vld <= '0;
            r_exp_sum <= '0;
            r_cmp_vld <= 1'b0;
            r_cmp_exp <= 17'd0;
            r_cmp_got <= 17'd0;
        end else begin
            r_exp_vld[0] <= w_issue;
            r_exp_sum[0] <= w_golden;
            for (int i = 1; i <= LAT; i++) begin
                r_exp_vld[i] <= r_exp_vld[i-1];
                r_exp_sum[i] <= r_exp_sum[i-1];
            end
            r_cmp_vld <= r_exp_vld[LAT];
            r_cmp_exp <= r_exp_sum[LAT];
            r_cmp_got <= {cout, s};
        end
    end

    assign w_mismatch = r_cmp_vld && (r_cmp_got != r_cmp_exp);

    // Saturating mismatch counter, cleared at the start of each run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 16'd0;
        end else if (w_entry) begin
            err_count <= 16'd0;
        end else if (w_mismatch && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

    assign pass = done && (err_count == 16'd0);

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    bist_vec_t [LAT:0] r_exp_vec;
    bist_vec_t         r_cmp_vec;

    // Operands follow the golden sum so the failing vector can be reported
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp_vec <= '0;
            r_cmp_vec <= '0;
        end else begin
            r_exp_vec[0] <= w_vec;
            for (int i = 1; i <= LAT; i++) begin
                r_exp_vec[i] <= r_exp_vec[i-1];
            end
            r_cmp_vec <= r_exp_vec[LAT];
        end
    end

    // Latch only the first mismatch of a run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_a     <= 16'd0;
            fail_b     <= 16'd0;
            fail_cin   <= 1'b0;
            fail_sum   <= 17'd0;
            fail_valid <= 1'b0;
        end else if (w_entry) begin
            fail_a     <= 16'd0;
            fail_b     <= 16'd0;
            fail_cin   <= 1'b0;
            fail_sum   <= 17'd0;
            fail_valid <= 1'b0;
        end else if (w_mismatch && !fail_valid) begin
            fail_a     <= r_cmp_vec.a;
            fail_b     <= r_cmp_vec.b;
            fail_cin   <= r_cmp_vec.cin;
            fail_sum   <= r_cmp_got;
            fail_valid <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_bist_ctrl
// Brief    : Self-checking bench for adder_bist_ctrl. Three instances:
//            LAT=0/1024 vectors, LAT=3/1024 vectors with a pipelined adder,
//            LAT=0/4 vectors. Expected vectors and error counts come from a
//            behavioural model of the vector list and adder faults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_bist_ctrl;

    localparam int          N0   = 1024;
    localparam int          N4   = 4;
    localparam logic [32:0] SEED = 33'h1_2345_6789;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- DUT signals ----------------
    logic        start0, start3, start4;
    logic [15:0] a0, b0, s0, a3, b3, s3, a4, b4, s4;
    logic        cin0, cout0, cin3, cout3, cin4, cout4;
    logic        busy0, done0, pass0, busy3, done3, pass3, busy4, done4, pass4;
    logic [15:0] err0, vc0, err3, vc3, err4, vc4;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    logic [15:0] fa0, fb0, fa3, fb3, fa4, fb4;
    logic        fc0, fv0, fc3, fv3, fc4, fv4;
    logic [16:0] fs0, fs3, fs4;
`endif

    int mode0 = 0;
    int mode4 = 0;

    // ---------------- model ----------------
    logic [15:0] m_a [N0];
    logic [15:0] m_b [N0];
    logic        m_c [N0];

    // Adder behaviour: mode 0 correct, 1 flips s[0] on FFFF+FFFF+1, 2 cout stuck at 0
    function automatic logic [16:0] adder_resp(input int mode, input logic [15:0] x,
                                               input logic [15:0] y, input logic ci);
        logic [16:0] r;
        r = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        if (mode == 1 && x == 16'hFFFF && y == 16'hFFFF && ci) r[0] = ~r[0];
        if (mode == 2) r[16] = 1'b0;
        return r;
    endfunction

    function automatic int model_errs(input int mode, input int n);
        int e;
        e = 0;
        for (int k = 0; k < n; k++)
            if (adder_resp(mode, m_a[k], m_b[k], m_c[k]) != adder_resp(0, m_a[k], m_b[k], m_c[k]))
                e++;
        return e;
    endfunction

    function automatic int model_first(input int mode, input int n);
        for (int k = 0; k < n; k++)
            if (adder_resp(mode, m_a[k], m_b[k], m_c[k]) != adder_resp(0, m_a[k], m_b[k], m_c[k]))
                return k;
        return -1;
    endfunction

    task automatic build_model();
        logic [63:0] st;
        logic        fb;
        m_a[0] = 16'h0000; m_b[0] = 16'h0000; m_c[0] = 1'b0;
        m_a[1] = 16'hFFFF; m_b[1] = 16'h0001; m_c[1] = 1'b0;
        m_a[2] = 16'hFFFF; m_b[2] = 16'hFFFF; m_c[2] = 1'b1;
        m_a[3] = 16'hAAAA; m_b[3] = 16'h5555; m_c[3] = 1'b1;
        st = {31'd0, SEED};
        for (int k = 4; k < N0; k++) begin
            m_a[k] = st[15:0];
            m_b[k] = st[31:16];
            m_c[k] = st[32];
            fb = st[32] ^ st[19];
            st = ((st << 1) | {63'd0, fb}) & 64'h1_FFFF_FFFF;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- adders under test ----------------
    assign {cout0, s0} = adder_resp(mode0, a0, b0, cin0);
    assign {cout4, s4} = adder_resp(mode4, a4, b4, cin4);

    logic [16:0] p1 = '0, p2 = '0, p3 = '0;
    always @(posedge clk) begin
        p1 <= adder_resp(0, a3, b3, cin3);
        p2 <= p1;
        p3 <= p2;
    end
    assign {cout3, s3} = p3;

    // ---------------- DUTs ----------------
    adder_bist_ctrl #(.NUM_VECTORS(N0), .LAT(0), .SEED(SEED)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0),
        .s(s0), .cout(cout0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .vec_count(vc0)
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
        , .fail_a(fa0), .fail_b(fb0), .fail_cin(fc0), .fail_sum(fs0), .fail_valid(fv0)
`endif
    );

    adder_bist_ctrl #(.NUM_VECTORS(N0), .LAT(3), .SEED(SEED)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .s(s3), .cout(cout3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .vec_count(vc3)
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
        , .fail_a(fa3), .fail_b(fb3), .fail_cin(fc3), .fail_sum(fs3), .fail_valid(fv3)
`endif
    );

    adder_bist_ctrl #(.NUM_VECTORS(N4), .LAT(0), .SEED(SEED)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .s(s4), .cout(cout4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .vec_count(vc4)
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
        , .fail_a(fa4), .fail_b(fb4), .fail_cin(fc4), .fail_sum(fs4), .fail_valid(fv4)
`endif
    );

    // ---------------- per-cycle compare for dut0 ----------------
    bit m_on = 1'b0;
    int m_t, m_exp_err, m_first;

    always @(negedge clk) begin : cmp0
        int d;
        if (m_on) begin
            d = cyc - m_t;
            if (d >= 1 && d <= N0) begin
                chk("run_busy", {31'd0, busy0}, 32'd1);
                chk("run_done", {31'd0, done0}, 32'd0);
                chk("vec_a", {16'd0, a0}, {16'd0, m_a[d-1]});
                chk("vec_b", {16'd0, b0}, {16'd0, m_b[d-1]});
                chk("vec_cin", {31'd0, cin0}, {31'd0, m_c[d-1]});
                chk("vec_count_run", {16'd0, vc0}, d);
            end else if (d > N0 && d <= N0 + 2) begin
                chk("drain_busy", {31'd0, busy0}, 32'd1);
                chk("drain_done", {31'd0, done0}, 32'd0);
                chk("drain_hold_a", {16'd0, a0}, {16'd0, m_a[N0-1]});
                chk("drain_vec_count", {16'd0, vc0}, N0);
            end else if (d == N0 + 3) begin
                chk("done_at_cycle", {31'd0, done0}, 32'd1);
                chk("done_busy", {31'd0, busy0}, 32'd0);
                chk("err_count", {16'd0, err0}, m_exp_err);
                chk("pass", {31'd0, pass0}, {31'd0, (m_exp_err == 0)});
                chk("vec_count_done", {16'd0, vc0}, N0);
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
                chk("fail_valid", {31'd0, fv0}, {31'd0, (m_first >= 0)});
                if (m_first >= 0) begin
                    chk("fail_a", {16'd0, fa0}, {16'd0, m_a[m_first]});
                    chk("fail_b", {16'd0, fb0}, {16'd0, m_b[m_first]});
                    chk("fail_cin", {31'd0, fc0}, {31'd0, m_c[m_first]});
                    chk("fail_sum", {15'd0, fs0},
                        {15'd0, adder_resp(mode0, m_a[m_first], m_b[m_first], m_c[m_first])});
                end
`endif
                m_on = 1'b0;
            end
        end
    end

    task automatic run0(input int mode, input bit spur);
        mode0     = mode;
        m_exp_err = model_errs(mode, N0);
        m_first   = model_first(mode, N0);
        @(posedge clk); #1;
        start0 = 1'b1; m_t = cyc; m_on = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int i = 0; i < N0 + 20 && m_on; i++) begin
            @(posedge clk); #1;
            if (spur && (cyc - m_t) <= N0) start0 = 1'($urandom_range(0, 1));
            else start0 = 1'b0;
        end
        start0 = 1'b0;
        if (m_on) begin
            n_assert++; n_fail++;
            $display("FAIL dut0_run_timeout: done not seen, required by cycle %0d", N0 + 3);
            m_on = 1'b0;
        end
    endtask

    task automatic run4(input int mode);
        logic [15:0] la [4];
        logic [15:0] lb [4];
        logic        lc [4];
        int t, d, e;
        bit seen;
        la = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hAAAA};
        lb = '{16'h0000, 16'h0001, 16'hFFFF, 16'h5555};
        lc = '{1'b0, 1'b0, 1'b1, 1'b1};
        mode4 = mode;
        e = model_errs(mode, N4);
        seen = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b1; t = cyc;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            d = cyc - t;
            if (d == 1) begin
                chk("n4_busy_rise", {31'd0, busy4}, 32'd1);
                chk("n4_done_drop", {31'd0, done4}, 32'd0);
                chk("n4_err_cleared", {16'd0, err4}, 32'd0);
            end
            if (d >= 1 && d <= 4) begin
                chk("n4_dir_a", {16'd0, a4}, {16'd0, la[d-1]});
                chk("n4_dir_b", {16'd0, b4}, {16'd0, lb[d-1]});
                chk("n4_dir_cin", {31'd0, cin4}, {31'd0, lc[d-1]});
            end
            if (done4) begin
                seen = 1'b1;
                chk("n4_done_cycle", d, 32'd7);
                break;
            end
        end
        if (!seen) begin
            n_assert++; n_fail++;
            $display("FAIL n4_done_timeout: done not seen, required at cycle 7");
        end
        chk("n4_err", {16'd0, err4}, e);
        chk("n4_pass", {31'd0, pass4}, {31'd0, (e == 0)});
        chk("n4_vec_count", {16'd0, vc4}, 32'd4);
    endtask

    task automatic run3();
        int t, d;
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        start3 = 1'b1; t = cyc;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int i = 0; i < N0 + 40; i++) begin
            @(negedge clk);
            d = cyc - t;
            if (d == 5) begin
                chk("lat3_v4_a", {16'd0, a3}, 32'h6789);
                chk("lat3_v4_b", {16'd0, b3}, 32'h2345);
                chk("lat3_v4_cin", {31'd0, cin3}, 32'd1);
            end
            if (d == 6) begin
                chk("lat3_v5_a", {16'd0, a3}, 32'hCF13);
                chk("lat3_v5_b", {16'd0, b3}, 32'h468A);
                chk("lat3_v5_cin", {31'd0, cin3}, 32'd0);
            end
            if (done3) begin
                seen = 1'b1;
                chk("lat3_done_cycle", d, N0 + 5);
                break;
            end
        end
        if (!seen) begin
            n_assert++; n_fail++;
            $display("FAIL lat3_done_timeout: done not seen, required at cycle %0d", N0 + 5);
        end
        chk("lat3_err", {16'd0, err3}, 32'd0);
        chk("lat3_pass", {31'd0, pass3}, 32'd1);
        chk("lat3_vec_count", {16'd0, vc3}, N0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start3 = 1'b0;
        start4 = 1'b0;
        build_model();

        // Pin the model with hand-computed values
        chk("model_golden_v2", {15'd0, adder_resp(0, 16'hFFFF, 16'hFFFF, 1'b1)}, 32'h1FFFF);
        chk("model_flip_v2", {15'd0, adder_resp(1, 16'hFFFF, 16'hFFFF, 1'b1)}, 32'h1FFFE);
        chk("model_dir_carries", model_errs(2, N4), 32'd3);
        chk("model_v5_a", {16'd0, m_a[5]}, 32'hCF13);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", {16'd0, a0}, 32'd0);
        chk("rst_b", {16'd0, b0}, 32'd0);
        chk("rst_cin", {31'd0, cin0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_pass", {31'd0, pass0}, 32'd0);
        chk("rst_err", {16'd0, err0}, 32'd0);
        chk("rst_vec_count", {16'd0, vc0}, 32'd0);
        rst_n = 1'b1;
        repeat ($urandom_range(1, 5)) @(posedge clk);

        // Directed-only runs: cout-stuck adder, then a clean rerun from DONE
        run4(2);
        repeat ($urandom_range(1, 5)) @(posedge clk);
        run4(0);

        // Full runs on LAT=0
        run0(0, 1'b1);
        run0(1, 1'b0);
        chk("flip_v2_err_literal", {16'd0, err0}, 32'd1);
        chk("flip_v2_pass_literal", {31'd0, pass0}, 32'd0);
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
        chk("flip_fail_a", {16'd0, fa0}, 32'hFFFF);
        chk("flip_fail_b", {16'd0, fb0}, 32'hFFFF);
        chk("flip_fail_cin", {31'd0, fc0}, 32'd1);
        chk("flip_fail_sum", {15'd0, fs0}, 32'h1FFFE);
`endif
        run0(2, 1'b1);

        // Pipelined adder
        run3();

        // Reset mid-run, then the sequence must restart from v0
        mode0 = 0;
        @(posedge clk); #1;
        start0 = 1'b1; m_t = cyc; m_on = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat ($urandom_range(20, 600)) @(posedge clk);
        #1;
        m_on  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_a", {16'd0, a0}, 32'd0);
        chk("midrst_b", {16'd0, b0}, 32'd0);
        chk("midrst_cin", {31'd0, cin0}, 32'd0);
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_done", {31'd0, done0}, 32'd0);
        chk("midrst_err", {16'd0, err0}, 32'd0);
        chk("midrst_vec_count", {16'd0, vc0}, 32'd0);
        chk("midrst_done3", {31'd0, done3}, 32'd0);
        chk("midrst_done4", {31'd0, done4}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run0(0, 1'b1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global bound so the run always terminates
    initial begin
        #2000000;
        n_assert++; n_fail++;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
